// File: rtl/cond_branch_op.sv
// rtl/cond_branch_op.sv - conditional-branch steering unit with condition FIFO
//
// Pairs each compare result with the next data/control token, strictly in
// arrival order. Each token goes to the taken (t_*) or not-taken (f_*) successor.
//
// Parameters:
//   ParamBitWidth  token payload width
//   ParamDepth     condition FIFO depth (power of two, >= 2)
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   enable                        global stall; low freezes all state
//   cond_valid/cond_ready/cond    compare-result input stream
//   tok_valid/tok_ready/tok_data  token input stream
//   t_valid/t_ready/t_data        taken-path output stream
//   f_valid/f_ready/f_data        not-taken-path output stream
//   taken_cnt, not_taken_cnt      saturating accept counters (COND_BRANCH_STATS_EN only)
// Optional feature macro: COND_BRANCH_STATS_EN
module cond_branch_op #(
    parameter int ParamBitWidth = 32,
    parameter int ParamDepth    = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     cond_valid,
    output logic                     cond_ready,
    input  logic                     cond,
    input  logic                     tok_valid,
    output logic                     tok_ready,
    input  logic [ParamBitWidth-1:0] tok_data,
    output logic                     t_valid,
    input  logic                     t_ready,
    output logic [ParamBitWidth-1:0] t_data,
    output logic                     f_valid,
    input  logic                     f_ready,
    output logic [ParamBitWidth-1:0] f_data
`ifdef COND_BRANCH_STATS_EN
    ,
    output logic [31:0]              taken_cnt,
    output logic [31:0]              not_taken_cnt
`endif
);

    localparam int AW = $clog2(ParamDepth);
    localparam int PW = AW + 1;

    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [ParamDepth-1:0]    cond_mem_q;
    logic                     t_valid_q, t_valid_d;
    logic                     f_valid_q, f_valid_d;
    logic [ParamBitWidth-1:0] t_data_q, t_data_d;
    logic [ParamBitWidth-1:0] f_data_q, f_data_d;

    logic full, empty, head, push, pop;
    logic t_free, f_free, load_t, load_f, t_drain, f_drain;

    always_comb begin
        full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty   = (wr_ptr_q == rd_ptr_q);
        head    = cond_mem_q[rd_ptr_q[AW-1:0]];
        t_free  = !t_valid_q || t_ready;
        f_free  = !f_valid_q || f_ready;

        // Readies are forced low while reset is asserted, not just after the
        // flops clear, so upstream never sees a handshake during reset.
        cond_ready = reset_n && enable && !full;
        tok_ready  = reset_n && enable && !empty && (head ? t_free : f_free);

        // A push decision uses the full flag of this cycle only, so a
        // simultaneous pop never lets a push into a full FIFO.
        push    = cond_valid && cond_ready;
        pop     = tok_valid && tok_ready;
        load_t  = pop && head;
        load_f  = pop && !head;
        t_drain = enable && t_valid_q && t_ready;
        f_drain = enable && f_valid_q && f_ready;

        wr_ptr_d = push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;

        // A reload in the same cycle as a drain keeps the side valid.
        t_valid_d = load_t ? 1'b1 : (t_drain ? 1'b0 : t_valid_q);
        f_valid_d = load_f ? 1'b1 : (f_drain ? 1'b0 : f_valid_q);
        t_data_d  = load_t ? tok_data : t_data_q;
        f_data_d  = load_f ? tok_data : f_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cond_mem_q <= '0;
            t_valid_q  <= 1'b0;
            f_valid_q  <= 1'b0;
            t_data_q   <= '0;
            f_data_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            t_valid_q <= t_valid_d;
            f_valid_q <= f_valid_d;
            t_data_q  <= t_data_d;
            f_data_q  <= f_data_d;
            if (push) begin
                cond_mem_q[wr_ptr_q[AW-1:0]] <= cond;
            end
        end
    end

    assign t_valid = t_valid_q && enable;
    assign f_valid = f_valid_q && enable;
    assign t_data  = t_data_q;
    assign f_data  = f_data_q;

`ifdef COND_BRANCH_STATS_EN
    logic [31:0] taken_cnt_q, not_taken_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taken_cnt_q     <= '0;
            not_taken_cnt_q <= '0;
        end else begin
            if (load_t && (taken_cnt_q != 32'hFFFF_FFFF)) begin
                taken_cnt_q <= taken_cnt_q + 32'd1;
            end
            if (load_f && (not_taken_cnt_q != 32'hFFFF_FFFF)) begin
                not_taken_cnt_q <= not_taken_cnt_q + 32'd1;
            end
        end
    end

    assign taken_cnt     = taken_cnt_q;
    assign not_taken_cnt = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_cond_branch_op.sv
// tb/tb_cond_branch_op.sv - scoreboard bench for cond_branch_op
module tb_cond_branch_op;

    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n, enable, cond_valid, cond, tok_valid, t_ready, f_ready;
    logic [W-1:0] tok_data;
    logic         cond_ready, tok_ready, t_valid, f_valid;
    logic [W-1:0] t_data, f_data;
`ifdef COND_BRANCH_STATS_EN
    logic [31:0]  taken_cnt, not_taken_cnt;
`endif

    always #5 clk = ~clk;

    cond_branch_op #(.ParamBitWidth(W), .ParamDepth(D)) dut (
        .clk(clk), .reset_n(rst_n), .enable(enable),
        .cond_valid(cond_valid), .cond_ready(cond_ready), .cond(cond),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_data(tok_data),
        .t_valid(t_valid), .t_ready(t_ready), .t_data(t_data),
        .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data)
`ifdef COND_BRANCH_STATS_EN
        , .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: conditions waiting for tokens, and per-side occupancy.
    bit           cq[$];
    logic [W-1:0] t_exp[$];
    logic [W-1:0] f_exp[$];
    bit           t_pend, f_pend;
    int           n_taken, n_not_taken;

    always @(negedge clk) begin
        bit exp_cr, exp_tr, hd, do_push, do_pop, t_dr, f_dr;
        if (!rst_n) begin
            cq.delete();
            t_pend = 0; f_pend = 0;
            n_taken = 0; n_not_taken = 0;
            chk("rst_cond_ready", cond_ready, 0);
            chk("rst_tok_ready", tok_ready, 0);
            chk("rst_t_valid", t_valid, 0);
            chk("rst_f_valid", f_valid, 0);
            chk("rst_t_data", t_data, 0);
            chk("rst_f_data", f_data, 0);
        end else begin
            hd     = (cq.size() > 0) ? cq[0] : 1'b0;
            exp_cr = enable && (cq.size() < D);
            exp_tr = enable && (cq.size() > 0) &&
                     (hd ? (!t_pend || t_ready) : (!f_pend || f_ready));
            chk("cond_ready", cond_ready, exp_cr);
            chk("tok_ready", tok_ready, exp_tr);
            chk("t_valid", t_valid, t_pend && enable);
            chk("f_valid", f_valid, f_pend && enable);
            do_push = cond_valid && exp_cr;
            do_pop  = tok_valid && exp_tr;
            t_dr    = t_pend && enable && t_ready;
            f_dr    = f_pend && enable && f_ready;
            if (t_dr) t_pend = 0;
            if (f_dr) f_pend = 0;
            if (do_pop) begin
                void'(cq.pop_front());
                if (hd) begin
                    t_exp.push_back(tok_data); t_pend = 1; n_taken++;
                end else begin
                    f_exp.push_back(tok_data); f_pend = 1; n_not_taken++;
                end
            end
            if (do_push) cq.push_back(cond);
        end
    end

    // Monitor: pops the expected payload whenever a side hands off a token.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst_n) begin
            t_exp.delete();
            f_exp.delete();
        end else begin
            if (t_valid && t_ready) begin
                if (t_exp.size() == 0) chk("t_unexpected", 1, 0);
                else begin e = t_exp.pop_front(); chk("t_data", t_data, e); end
            end
            if (f_valid && f_ready) begin
                if (f_exp.size() == 0) chk("f_unexpected", 1, 0);
                else begin e = f_exp.pop_front(); chk("f_data", f_data, e); end
            end
        end
    end

    task automatic drive(input bit cv, input bit c, input bit tv, input logic [W-1:0] td,
                         input bit tr, input bit fr, input bit en);
        @(posedge clk);
        #1;
        cond_valid = cv; cond = c; tok_valid = tv; tok_data = td;
        t_ready = tr; f_ready = fr; enable = en;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; cond_valid = 1'b0; cond = 1'b0;
        tok_valid = 1'b0; tok_data = '0; t_ready = 1'b0; f_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single taken token.
        drive(1, 1, 0, 0, 1, 1, 1);
        drive(0, 0, 1, 32'h0000_00A5, 1, 1, 1);
        repeat (3) drive(0, 0, 0, 0, 1, 1, 1);

        // Fill the FIFO with 1,0,1,0 plus one refused push, then drain with tokens 1..4.
        for (int i = 0; i < 5; i++) drive(1, (i % 2) == 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, i + 1, 1, 1, 1);
        repeat (2) drive(0, 0, 0, 0, 1, 1, 1);

        // Taken side blocked: the not-taken token behind it must wait.
        drive(1, 1, 0, 0, 0, 1, 1);
        drive(1, 1, 1, 32'h11, 0, 1, 1);
        drive(1, 0, 1, 32'h22, 0, 1, 1);
        repeat (3) drive(0, 0, 1, 32'h33, 0, 1, 1);
        repeat (4) drive(0, 0, 1, 32'h44, 1, 1, 1);

        // Enable low mid-stream for 3 cycles.
        drive(1, 0, 1, 32'h55, 1, 1, 1);
        repeat (3) drive(1, 1, 1, 32'h66, 1, 1, 0);
        repeat (3) drive(0, 0, 1, 32'h77, 1, 1, 1);

        // Randomized traffic with a reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                drive(1, 1, 0, 0, 0, 0, 1);
                drive(1, 0, 1, $urandom, 0, 0, 1);
                #1 rst_n = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, $urandom,
                  ((i % 200) < 30) ? 1'b0 : ($urandom_range(0, 3) != 0),
                  ((i % 300) > 260) ? 1'b0 : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 9) != 0);
        end

        repeat (10) drive(0, 0, 0, 0, 1, 1, 1);
        @(negedge clk);
        chk("t_left_over", t_exp.size(), 0);
        chk("f_left_over", f_exp.size(), 0);
`ifdef COND_BRANCH_STATS_EN
        chk("taken_cnt", taken_cnt, n_taken);
        chk("not_taken_cnt", not_taken_cnt, n_not_taken);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cond_branch_op.md
# cond_branch_op

Conditional-branch steering unit for the generated datapath library. It consumes the 1-bit result of an integer-compare operator and a data/control token, and routes each token to the taken (true) or not-taken (false) successor. It sits directly downstream of the compare operators, at the boundary of each branching basic block. A small condition FIFO decouples compare latency from token arrival.

## Interface
- ParamBitWidth, 32, token payload width
- ParamDepth, 4, condition FIFO depth; power of two, ≥2
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  global stall; low freezes all state
- cond_valid  in  1  condition bit valid
- cond_ready  out  1  condition FIFO can accept
- cond  in  1  compare result; 1 = taken
- tok_valid  in  1  token valid
- tok_ready  out  1  token accepted this cycle when high with tok_valid
- tok_data  in  ParamBitWidth  token payload
- t_valid  out  1  taken-path token valid
- t_ready  in  1  taken-path consumer ready
- t_data  out  ParamBitWidth  taken-path payload
- f_valid  out  1  not-taken-path token valid
- f_ready  in  1  not-taken-path consumer ready
- f_data  out  ParamBitWidth  not-taken-path payload

## Operation
- Condition FIFO: ParamDepth entries, read/write pointers of log2(ParamDepth)+1 bits. Full = MSBs differ and low bits equal. Empty = pointers equal. Pointers wrap naturally.
- cond_ready = enable & !full. Push on cond_valid & cond_ready.
- No pass-through: a push while full is refused, even if a pop occurs in the same cycle.
- Head entry (head) selects the destination of the next token. Tokens and conditions pair strictly in arrival order.
- Per-side output register: one entry each, holding valid_q and data_q. A side is free when !valid_q or its consumer is ready.
- tok_ready = enable & !empty & (head ? t_free : f_free).
- On token accept, in one cycle:
  - load data into the selected side register and set its valid_q;
  - pop the FIFO.
- On t_valid & t_ready, clear t valid_q unless reloaded in the same cycle. The f side behaves identically.
- t_valid = t_valid_q & enable and f_valid = f_valid_q & enable. Output data is held while valid.
- enable low: no push, pop, load or drain. All registers hold.
- Reset (async assert, sync release via clk domain):
  - FIFO empty;
  - t_valid_q, f_valid_q = 0; t_data, f_data = 0;
  - cond_ready = tok_ready = 0 while reset_n is low;
  - stats counters = 0.
- Reset mid-operation discards all queued conditions and buffered tokens.

## Timing
- Condition pushed in cycle N is visible at head in N+1. There is no bypass.
- Token accepted in cycle N drives x_valid in N+1.
- Minimum cond→output latency is 2 cycles. Minimum token→output latency is 1 cycle.
- Throughput is one token per cycle when the selected consumer is ready every cycle. Alternating sides also sustains 1/cycle.
- Back-pressure on one side blocks all later tokens, including those headed to the other side.

## Configuration
- COND_BRANCH_STATS_EN defined:
  - adds outputs taken_cnt [31:0] and not_taken_cnt [31:0];
  - each counter increments on a token accept to its side;
  - counters saturate at 32'hFFFF_FFFF and reset to 0.
- COND_BRANCH_STATS_EN undefined: the ports and counters are absent. Datapath behaviour is identical.

## Test plan
- Reset release; push cond=1, then token 0x0000_00A5 with t_ready=1. Expect t_valid one cycle after accept, t_data=0x0000_00A5, f_valid never high.
- Push 4 conditions 1,0,1,0 with ParamDepth=4 and no tokens. Expect cond_ready=0 after the 4th push. Then send tokens 1..4 with both sides ready. Expect tokens 1 and 3 on t, 2 and 4 on f, in order.
- Head=1 with t_ready=0 and t_valid_q set; offer a token. Expect tok_ready=0 until t_ready=1. The following cond=0 token waits behind it.
- Drop enable for 3 cycles mid-stream. Expect all valids low, readies low, and state unchanged. Streaming resumes without loss or duplication.
- Assert reset_n low with 2 queued conditions and t_valid_q set. Expect all outputs 0 immediately and FIFO empty after release.
- With COND_BRANCH_STATS_EN defined, send 5 taken and 3 not-taken tokens. Expect taken_cnt=5 and not_taken_cnt=3.
